// File: rtl/round_sequencer.sv
// Round controller for the counting game: picks a random target, shows it,
// collects the player's up/down count within a time limit, scores the round.
module round_sequencer #(
   parameter int SHOW_SECS   = 3,
   parameter int ANSWER_SECS = 5,
   parameter int RESULT_SECS = 2,
   parameter int MAX_ROUNDS  = 8,
   parameter int MAX_COUNT   = 9
) (
   input  logic       Clk100M,
   input  logic       reset,
   input  logic       tick1Hz,
   input  logic       startB,
   input  logic       upB,
   input  logic       downB,
   output logic [3:0] target,
   output logic [3:0] guess,
   output logic [3:0] secsLeft,
   output logic [3:0] score,
   output logic [3:0] round,
   output logic [2:0] state,
   output logic       showTarget,
   output logic       correct,
   output logic       gameOver
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SHOW   = 3'd2,
      ANSWER = 3'd3,
      CHECK  = 3'd4,
      RESULT = 3'd5,
      DONE   = 3'd6
   } state_t;

   localparam logic [3:0] SHOW_S   = 4'(SHOW_SECS);
   localparam logic [3:0] ANSWER_S = 4'(ANSWER_SECS);
   localparam logic [3:0] RESULT_S = 4'(RESULT_SECS);
   localparam logic [3:0] ROUNDS_N = 4'(MAX_ROUNDS);
   localparam logic [3:0] MAX_C    = 4'(MAX_COUNT);

   state_t     state_reg, state_next;
   logic [7:0] lfsr_reg, lfsr_next;
   logic [3:0] target_reg, target_next;
   logic [3:0] guess_reg, guess_next;
   logic [3:0] secs_reg, secs_next;
   logic [3:0] score_reg, score_next;
   logic [3:0] round_reg, round_next;
   logic       correct_reg, correct_next;

   logic       lfsr_fb;
   logic [3:0] lfsr_nib;
   logic [3:0] load_target;
   logic       match;

   // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting toward the MSB
   assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
   assign lfsr_next[0] = lfsr_fb;

   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_lfsr_shift
         assign lfsr_next[gi] = lfsr_reg[gi-1];
      end
   endgenerate

   // Fold the random nibble into 1..MAX_COUNT; zero maps to 1
   assign lfsr_nib = lfsr_reg[3:0];
   always_comb begin
      load_target = lfsr_nib;
      if (lfsr_nib == 4'd0) begin
         load_target = 4'd1;
      end else if (lfsr_nib > MAX_C) begin
         load_target = lfsr_nib - MAX_C;
      end
   end

   assign match = (guess_reg == target_reg);

   always_ff @(posedge Clk100M) begin
      if (reset) begin
         state_reg   <= IDLE;
         lfsr_reg    <= 8'hA5;
         target_reg  <= 4'd0;
         guess_reg   <= 4'd0;
         secs_reg    <= 4'd0;
         score_reg   <= 4'd0;
         round_reg   <= 4'd0;
         correct_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         lfsr_reg    <= lfsr_next;
         target_reg  <= target_next;
         guess_reg   <= guess_next;
         secs_reg    <= secs_next;
         score_reg   <= score_next;
         round_reg   <= round_next;
         correct_reg <= correct_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      target_next  = target_reg;
      guess_next   = guess_reg;
      secs_next    = secs_reg;
      score_next   = score_reg;
      round_next   = round_reg;
      correct_next = correct_reg;

      case (state_reg)
         IDLE: begin
            if (startB) begin
               state_next = LOAD;
               score_next = 4'd0;
               round_next = 4'd0;
            end
         end

         LOAD: begin
            target_next  = load_target;
            guess_next   = 4'd0;
            correct_next = 1'b0;
            secs_next    = SHOW_S;
            state_next   = SHOW;
         end

         SHOW: begin
            if (tick1Hz) begin
               if (secs_reg == 4'd1) begin
                  state_next = ANSWER;
                  secs_next  = ANSWER_S;
               end else begin
                  secs_next = secs_reg - 4'd1;
               end
            end
         end

         ANSWER: begin
            if (startB) begin
               // early submit wins over the tick and discards any blip
               state_next = CHECK;
            end else begin
               if (upB && !downB && (guess_reg < MAX_C)) begin
                  guess_next = guess_reg + 4'd1;
               end else if (downB && !upB && (guess_reg != 4'd0)) begin
                  guess_next = guess_reg - 4'd1;
               end
               if (tick1Hz) begin
                  if (secs_reg == 4'd1) begin
                     state_next = CHECK;
                  end else begin
                     secs_next = secs_reg - 4'd1;
                  end
               end
            end
         end

         CHECK: begin
            correct_next = match;
            if (match && (score_reg != 4'd15)) begin
               score_next = score_reg + 4'd1;
            end
            round_next = round_reg + 4'd1;
            secs_next  = RESULT_S;
            state_next = RESULT;
         end

         RESULT: begin
            if (tick1Hz) begin
               if (secs_reg == 4'd1) begin
                  state_next = (round_reg == ROUNDS_N) ? DONE : LOAD;
               end else begin
                  secs_next = secs_reg - 4'd1;
               end
            end
         end

         DONE: begin
            if (startB) begin
               score_next = 4'd0;
               round_next = 4'd0;
               state_next = LOAD;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign target     = target_reg;
   assign guess      = guess_reg;
   assign secsLeft   = secs_reg;
   assign score      = score_reg;
   assign round      = round_reg;
   assign state      = state_reg;
   assign correct    = correct_reg;
   assign showTarget = (state_reg == SHOW);
   assign gameOver   = (state_reg == DONE);

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: a short two-round game, saturation,
// timeout, submit-vs-tick priority and mid-round reset.
module tb_round_sequencer;

   logic       clk;
   logic       reset;
   logic       tick1Hz;
   logic       startB;
   logic       upB;
   logic       downB;
   logic [3:0] target;
   logic [3:0] guess;
   logic [3:0] secsLeft;
   logic [3:0] score;
   logic [3:0] round;
   logic [2:0] state;
   logic       showTarget;
   logic       correct;
   logic       gameOver;

   int checks_cnt = 0;
   int fail_cnt   = 0;

   logic [7:0] lfsr_model;
   logic [7:0] nx;
   int         found;
   int         exp_t;
   int         exp_c;

   round_sequencer #(
      .SHOW_SECS  (3),
      .ANSWER_SECS(5),
      .RESULT_SECS(2),
      .MAX_ROUNDS (2),
      .MAX_COUNT  (9)
   ) dut (
      .Clk100M   (clk),
      .reset     (reset),
      .tick1Hz   (tick1Hz),
      .startB    (startB),
      .upB       (upB),
      .downB     (downB),
      .target    (target),
      .guess     (guess),
      .secsLeft  (secsLeft),
      .score     (score),
      .round     (round),
      .state     (state),
      .showTarget(showTarget),
      .correct   (correct),
      .gameOver  (gameOver)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] lfsr_step(input logic [7:0] x);
      return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
   endfunction

   function automatic int fold_target(input logic [3:0] v);
      if (v == 4'd0) return 1;
      if (v > 4'd9) return int'(v) - 9;
      return int'(v);
   endfunction

   // reference random source, reseeded by reset like the design's
   always @(posedge clk) begin
      if (reset) lfsr_model <= 8'hA5;
      else       lfsr_model <= lfsr_step(lfsr_model);
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks_cnt++;
      if (obs != exp) begin
         fail_cnt++;
         $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end else begin
         $display("check %s got=%0d", tag, obs);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic tick();
      tick1Hz = 1'b1;
      cyc();
      tick1Hz = 1'b0;
   endtask

   task automatic pulse_up();
      upB = 1'b1;
      cyc();
      upB = 1'b0;
   endtask

   task automatic pulse_down();
      downB = 1'b1;
      cyc();
      downB = 1'b0;
   endtask

   task automatic pulse_start();
      startB = 1'b1;
      cyc();
      startB = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; tick1Hz = 1'b0; startB = 1'b0; upB = 1'b0; downB = 1'b0;
      @(negedge clk);
      cyc();
      reset = 1'b0;
      repeat (100) cyc();

      check("rst_state", state, 0);
      check("rst_target", target, 0);
      check("rst_guess", guess, 0);
      check("rst_secs", secsLeft, 0);
      check("rst_score", score, 0);
      check("rst_round", round, 0);
      check("rst_show", showTarget, 0);
      check("rst_correct", correct, 0);
      check("rst_gameover", gameOver, 0);

      // time startB so the nibble seen in LOAD is 4'hC
      found = 0;
      for (int i = 0; i < 300; i++) begin
         nx = lfsr_step(lfsr_model);
         if (nx[3:0] == 4'hC) begin
            pulse_start();
            found = 1;
            break;
         end
         cyc();
      end
      check("lfsr_c_found", found, 1);
      check("load_state", state, 1);
      cyc();
      check("show_state", state, 2);
      check("show_target", target, 3);
      check("show_secs", secsLeft, 3);
      check("show_flag", showTarget, 1);

      pulse_up();
      check("up_in_show", guess, 0);
      pulse_start();
      check("start_in_show", state, 2);

      tick();
      check("show_tick1", secsLeft, 2);
      tick();
      tick();
      check("answer_state", state, 3);
      check("answer_secs", secsLeft, 5);
      check("answer_show", showTarget, 0);

      repeat (12) pulse_up();
      check("sat_up", guess, 9);
      repeat (11) pulse_down();
      check("sat_down", guess, 0);
      repeat (3) pulse_up();
      check("up3", guess, 3);
      upB = 1'b1; downB = 1'b1;
      cyc();
      upB = 1'b0; downB = 1'b0;
      check("up_down_both", guess, 3);

      startB = 1'b1; upB = 1'b1;
      cyc();
      startB = 1'b0; upB = 1'b0;
      check("submit_state", state, 4);
      check("submit_drop_up", guess, 3);
      cyc();
      check("res1_state", state, 5);
      check("res1_correct", correct, 1);
      check("res1_score", score, 1);
      check("res1_round", round, 1);
      check("res1_secs", secsLeft, 2);

      tick();
      check("res1_tick", secsLeft, 1);
      tick();
      check("load2_state", state, 1);
      exp_t = fold_target(lfsr_model[3:0]);
      cyc();
      check("show2_state", state, 2);
      check("show2_target", target, exp_t);
      check("show2_guess", guess, 0);
      check("show2_correct", correct, 0);

      repeat (3) tick();
      check("answer2_state", state, 3);
      repeat (4) tick();
      check("answer2_secs", secsLeft, 1);
      tick1Hz = 1'b1; upB = 1'b1;
      cyc();
      tick1Hz = 1'b0; upB = 1'b0;
      check("timeout_state", state, 4);
      check("timeout_up_kept", guess, 1);
      exp_c = (exp_t == 1) ? 1 : 0;
      cyc();
      check("res2_state", state, 5);
      check("res2_correct", correct, exp_c);
      check("res2_score", score, 1 + exp_c);
      check("res2_round", round, 2);

      tick();
      tick();
      check("done_state", state, 6);
      check("done_gameover", gameOver, 1);
      check("done_round", round, 2);
      check("done_target", target, exp_t);
      tick();
      check("done_tick_ignored", state, 6);
      pulse_up();
      check("done_up_ignored", guess, 1);

      pulse_start();
      check("restart_state", state, 1);
      check("restart_round", round, 0);
      check("restart_score", score, 0);
      check("restart_gameover", gameOver, 0);

      cyc();
      repeat (3) tick();
      check("answer3_state", state, 3);
      tick();
      check("answer3_secs", secsLeft, 4);
      tick1Hz = 1'b1; startB = 1'b1;
      cyc();
      tick1Hz = 1'b0; startB = 1'b0;
      check("start_tick_state", state, 4);
      check("start_tick_secs", secsLeft, 4);
      cyc();
      check("res3_round", round, 1);

      tick();
      tick();
      check("load4_state", state, 1);
      cyc();
      repeat (3) tick();
      check("answer4_state", state, 3);
      reset = 1'b1; upB = 1'b1;
      cyc();
      reset = 1'b0; upB = 1'b0;
      check("midrst_state", state, 0);
      check("midrst_score", score, 0);
      check("midrst_round", round, 0);
      check("midrst_guess", guess, 0);
      check("midrst_target", target, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
